bmem_line_adapter: RTL and testbench

//  Sits between the CPU's I/D caches and the banked-memory port (bmem_*) at the cpu top level.

---
 rtl/bmem_adapter_pkg.sv | 21 ++
 rtl/bmem_line_adapter_rr_arb2.sv | 37 +++
 rtl/bmem_line_adapter.sv | 153 +++++++++++++++
 tb/tb_bmem_line_adapter.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bmem_adapter_pkg.sv
// Shared types and constants for the cache-line to banked-memory adapter.
package bmem_adapter_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RD_CMD,
        RD_BEAT,
        WR_BEAT,
        RESP
    } state_e;

    typedef enum logic {
        CL_I = 1'b0,
        CL_D = 1'b1
    } client_e;

    localparam int unsigned BEATS      = 4;
    localparam int unsigned BEAT_IDX_W = $clog2(BEATS);
    localparam int unsigned LINE_OFS_W = 5;

endpackage

// File: rtl/bmem_line_adapter_rr_arb2.sv
// Two-requester round-robin arbiter: on contention the grant goes to the
// client that was not granted last; rr_last only moves when a grant is taken.
module rr_arb2
    import bmem_adapter_pkg::*;
(
    input  logic    clk,
    input  logic    rst,
    input  logic    req_i,
    input  logic    req_d,
    input  logic    take,
    output logic    gnt_valid,
    output client_e gnt
);

    client_e rr_last_q;
    client_e rr_last_d;

    always_comb begin
        gnt_valid = req_i | req_d;
        if (req_i && req_d) begin
            if (rr_last_q == CL_I) gnt = CL_D;
            else                   gnt = CL_I;
        end else if (req_d) begin
            gnt = CL_D;
        end else begin
            gnt = CL_I;
        end
        rr_last_d = rr_last_q;
        if (take && gnt_valid) rr_last_d = gnt;
    end

    always_ff @(posedge clk) begin
        if (!rst) rr_last_q <= CL_I;
        else      rr_last_q <= rr_last_d;
    end

endmodule

// File: rtl/bmem_line_adapter.sv
// Arbitrates I/D cache line requests onto the banked-memory port, splitting
// each line into 64-bit beats and reassembling read beats into a line.
module bmem_line_adapter
    import bmem_adapter_pkg::*;
#(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned LINE_W = 256,
    parameter int unsigned BEAT_W = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic              i_read,
    output logic [LINE_W-1:0] i_rdata,
    output logic              i_resp,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [LINE_W-1:0] d_wdata,
    output logic [LINE_W-1:0] d_rdata,
    output logic              d_resp,
    output logic [ADDR_W-1:0] bmem_addr,
    output logic              bmem_read,
    output logic              bmem_write,
    output logic [BEAT_W-1:0] bmem_wdata,
    input  logic              bmem_ready,
    input  logic [ADDR_W-1:0] bmem_raddr,
    input  logic [BEAT_W-1:0] bmem_rdata,
    input  logic              bmem_rvalid,
    output logic              err
);

    localparam logic [ADDR_W-1:0]     OFS_MASK  = ADDR_W'((1 << LINE_OFS_W) - 1);
    localparam logic [BEAT_IDX_W-1:0] LAST_BEAT = BEAT_IDX_W'(BEATS - 1);

    state_e                state_q,   state_d;
    client_e               gnt_q,     gnt_d;
    logic [ADDR_W-1:0]     addr_q,    addr_d;
    logic [LINE_W-1:0]     wdata_q,   wdata_d;
    logic [BEAT_IDX_W-1:0] beat_q,    beat_d;
    logic [LINE_W-1:0]     i_rdata_q, i_rdata_d;
    logic [LINE_W-1:0]     d_rdata_q, d_rdata_d;
    logic                  err_q,     err_d;
    logic                  fresh_q,   fresh_d;

    logic    arb_valid;
    client_e arb_gnt;

    rr_arb2 u_arb (
        .clk      (clk),
        .rst      (rst),
        .req_i    (i_read),
        .req_d    (d_read | d_write),
        .take     (state_q == IDLE),
        .gnt_valid(arb_valid),
        .gnt      (arb_gnt)
    );

    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        beat_d    = beat_q;
        i_rdata_d = i_rdata_q;
        d_rdata_d = d_rdata_q;
        err_d     = err_q;
        fresh_d   = fresh_q;

        case (state_q)
            IDLE: begin
                // Beats trailing a reset-aborted read are expected; only flag once a grant has happened.
                if (bmem_rvalid && !fresh_q) err_d = 1'b1;
                if (arb_valid) begin
                    gnt_d   = arb_gnt;
                    beat_d  = '0;
                    fresh_d = 1'b0;
                    addr_d  = ((arb_gnt == CL_D) ? d_addr : i_addr) & ~OFS_MASK;
                    if (arb_gnt == CL_D && d_write) begin
                        wdata_d = d_wdata;
                        state_d = WR_BEAT;
                        if (d_read) err_d = 1'b1;
                    end else begin
                        state_d = RD_CMD;
                    end
                end
            end
            RD_CMD: begin
                if (bmem_rvalid) err_d = 1'b1;
                if (bmem_ready) state_d = RD_BEAT;
            end
            RD_BEAT: begin
                if (bmem_rvalid) begin
                    if (bmem_raddr == addr_q) begin
                        if (gnt_q == CL_I) i_rdata_d[int'(beat_q)*BEAT_W +: BEAT_W] = bmem_rdata;
                        else               d_rdata_d[int'(beat_q)*BEAT_W +: BEAT_W] = bmem_rdata;
                        if (beat_q == LAST_BEAT) state_d = RESP;
                        else                     beat_d  = beat_q + BEAT_IDX_W'(1);
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            WR_BEAT: begin
                if (bmem_rvalid) err_d = 1'b1;
                if (bmem_ready) begin
                    if (beat_q == LAST_BEAT) state_d = RESP;
                    else                     beat_d  = beat_q + BEAT_IDX_W'(1);
                end
            end
            RESP: begin
                if (bmem_rvalid) err_d = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= IDLE;
            gnt_q     <= CL_I;
            addr_q    <= '0;
            wdata_q   <= '0;
            beat_q    <= '0;
            i_rdata_q <= '0;
            d_rdata_q <= '0;
            err_q     <= 1'b0;
            fresh_q   <= 1'b1;
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            beat_q    <= beat_d;
            i_rdata_q <= i_rdata_d;
            d_rdata_q <= d_rdata_d;
            err_q     <= err_d;
            fresh_q   <= fresh_d;
        end
    end

    assign bmem_read  = (state_q == RD_CMD);
    assign bmem_write = (state_q == WR_BEAT);
    assign bmem_addr  = (bmem_read || bmem_write) ? addr_q : '0;
    assign bmem_wdata = bmem_write ? wdata_q[int'(beat_q)*BEAT_W +: BEAT_W] : '0;
    assign i_resp     = (state_q == RESP) && (gnt_q == CL_I);
    assign d_resp     = (state_q == RESP) && (gnt_q == CL_D);
    assign i_rdata    = i_rdata_q;
    assign d_rdata    = d_rdata_q;
    assign err        = err_q;

endmodule

// File: tb/tb_bmem_line_adapter.sv
// Directed + randomized bench for bmem_line_adapter with a line-level memory/client model.
module tb_bmem_line_adapter;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic [31:0]  i_addr = '0;
    logic         i_read = 1'b0;
    logic [255:0] i_rdata;
    logic         i_resp;
    logic [31:0]  d_addr = '0;
    logic         d_read = 1'b0;
    logic         d_write = 1'b0;
    logic [255:0] d_wdata = '0;
    logic [255:0] d_rdata;
    logic         d_resp;
    logic [31:0]  bmem_addr;
    logic         bmem_read;
    logic         bmem_write;
    logic [63:0]  bmem_wdata;
    logic         bmem_ready = 1'b1;
    logic [31:0]  bmem_raddr = '0;
    logic [63:0]  bmem_rdata = '0;
    logic         bmem_rvalid = 1'b0;
    logic         err;

    always #5 clk = ~clk;

    bmem_line_adapter #(.ADDR_W(32), .LINE_W(256), .BEAT_W(64)) dut (
        .clk(clk), .rst(rst),
        .i_addr(i_addr), .i_read(i_read), .i_rdata(i_rdata), .i_resp(i_resp),
        .d_addr(d_addr), .d_read(d_read), .d_write(d_write), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_resp(d_resp),
        .bmem_addr(bmem_addr), .bmem_read(bmem_read), .bmem_write(bmem_write),
        .bmem_wdata(bmem_wdata), .bmem_ready(bmem_ready), .bmem_raddr(bmem_raddr),
        .bmem_rdata(bmem_rdata), .bmem_rvalid(bmem_rvalid), .err(err)
    );

    int total = 0;
    int bad   = 0;

    // Bus monitor, sampled mid-cycle.
    logic [63:0] wr_all[$];
    logic [63:0] wr_acc[$];
    logic [31:0] wr_addr[$];
    int cmd_n = 0, i_resp_n = 0, d_resp_n = 0, overlap_n = 0;
    always @(negedge clk) begin
        if (bmem_read && bmem_write) overlap_n++;
        if (bmem_read && bmem_ready) cmd_n++;
        if (bmem_write) begin
            wr_all.push_back(bmem_wdata);
            wr_addr.push_back(bmem_addr);
            if (bmem_ready) wr_acc.push_back(bmem_wdata);
        end
        if (i_resp) i_resp_n++;
        if (d_resp) d_resp_n++;
    end

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic reset_dut;
        rst = 1'b0; i_read = 1'b0; d_read = 1'b0; d_write = 1'b0;
        bmem_rvalid = 1'b0; bmem_ready = 1'b1;
        repeat (2) tick;
        rst = 1'b1;
    endtask

    function automatic logic [255:0] rnd_line;
        return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    endfunction

    // Memory side of one read: accept the command, return the 4 beats 'delay' cycles later.
    task automatic serve_read(input string tag, input logic [31:0] addr, input logic [255:0] line,
                              input int delay, input bit stray);
        bit seen;
        seen = 1'b0;
        for (int c = 0; c < 40 && !seen; c++) begin
            if (bmem_read && bmem_ready) seen = 1'b1;
            else tick;
        end
        chk({tag, " cmd"}, seen, 1);
        if (!seen) return;
        chk({tag, " cmd_addr"}, bmem_addr, addr);
        tick;
        repeat (delay - 1) tick;
        for (int k = 0; k < 4; k++) begin
            if (stray && k == 2) begin
                bmem_rvalid = 1'b1; bmem_raddr = 32'hDEAD_0000; bmem_rdata = {$urandom, $urandom};
                tick;
            end
            bmem_rvalid = 1'b1; bmem_raddr = addr; bmem_rdata = line[k*64 +: 64];
            tick;
        end
        bmem_rvalid = 1'b0; bmem_raddr = '0; bmem_rdata = '0;
    endtask

    // Memory side of one write: drive ready (fixed stall or random) until 4 beats are accepted.
    task automatic serve_write(input string tag, input int stall_beat, input int stall_len, input bit rnd);
        int acc, st, c;
        acc = 0; st = 0; c = 0;
        while (acc < 4 && c < 60) begin
            if (bmem_write) begin
                if (rnd)                                     bmem_ready = ($urandom_range(0, 2) != 0);
                else if (acc == stall_beat && st < stall_len) begin bmem_ready = 1'b0; st++; end
                else                                         bmem_ready = 1'b1;
                if (bmem_ready) acc++;
            end
            tick; c++;
        end
        bmem_ready = 1'b1;
        chk({tag, " beats"}, acc, 4);
    endtask

    task automatic wait_resp(input string tag, output bit gi, output bit gd);
        bit found;
        found = 1'b0; gi = 1'b0; gd = 1'b0;
        for (int c = 0; c < 60 && !found; c++) begin
            if (i_resp || d_resp) begin found = 1'b1; gi = i_resp; gd = d_resp; end
            else tick;
        end
        chk({tag, " resp"}, found, 1);
    endtask

    logic [255:0] line, li, ld, d_model;
    logic [31:0]  a, ai, ad;
    bit gi, gd, last_d, pend_i, pend_d, exp_d;
    int n0, kind;
    int exp_idx[6] = '{0, 1, 2, 2, 2, 3};

    initial begin
        reset_dut();
        d_model = '0;
        chk("rst i_rdata", i_rdata, 0);
        chk("rst d_rdata", d_rdata, 0);
        chk("rst err", err, 0);
        chk("rst bus", {bmem_read, bmem_write, i_resp, d_resp}, 0);
        chk("rst addr", bmem_addr, 0);

        // 1: icache read, beats 3 cycles after command
        line = rnd_line(); n0 = cmd_n;
        i_addr = 32'h1000_0040; i_read = 1'b1;
        serve_read("t1", 32'h1000_0040, line, 3, 1'b0);
        wait_resp("t1", gi, gd);
        chk("t1 who", {gi, gd}, 2'b10);
        chk("t1 line", i_rdata, line);
        i_read = 1'b0;
        tick;
        chk("t1 pulse", i_resp, 0);
        chk("t1 cmds", cmd_n - n0, 1);
        chk("t1 err", err, 0);

        // 2: dcache write with ready low for 2 cycles on beat 2
        line = rnd_line(); wr_all.delete(); wr_addr.delete(); n0 = d_resp_n;
        d_addr = 32'h2000_0020; d_wdata = line; d_write = 1'b1;
        serve_write("t2", 2, 2, 1'b0);
        wait_resp("t2", gi, gd);
        chk("t2 who", {gi, gd}, 2'b01);
        d_write = 1'b0;
        tick;
        chk("t2 resp_n", d_resp_n - n0, 1);
        chk("t2 nbeat", wr_all.size(), 6);
        for (int i = 0; i < wr_all.size() && i < 6; i++) begin
            chk($sformatf("t2 beat%0d", i), wr_all[i], line[exp_idx[i]*64 +: 64]);
            chk($sformatf("t2 addr%0d", i), wr_addr[i], 32'h2000_0020);
        end
        chk("t2 d_rdata", d_rdata, d_model);

        // 3: simultaneous I/D reads twice; grants alternate starting with D
        reset_dut();
        d_model = '0; last_d = 1'b0;
        for (int r = 0; r < 2; r++) begin
            ai = $urandom; ad = $urandom; li = rnd_line(); ld = rnd_line();
            i_addr = ai; d_addr = ad; i_read = 1'b1; d_read = 1'b1;
            pend_i = 1'b1; pend_d = 1'b1;
            for (int s = 0; s < 2; s++) begin
                exp_d = (pend_i && pend_d) ? !last_d : pend_d;
                serve_read("t3", exp_d ? {ad[31:5], 5'b0} : {ai[31:5], 5'b0}, exp_d ? ld : li, 2, 1'b0);
                wait_resp("t3", gi, gd);
                chk($sformatf("t3 r%0d s%0d who", r, s), {gi, gd}, {!exp_d, exp_d});
                chk("t3 line", exp_d ? d_rdata : i_rdata, exp_d ? ld : li);
                if (exp_d) begin d_read = 1'b0; pend_d = 1'b0; d_model = ld; end
                else       begin i_read = 1'b0; pend_i = 1'b0; end
                last_d = exp_d;
                tick;
                chk("t3 pulse", {i_resp, d_resp}, 0);
            end
        end

        // 4: stray beat with foreign tag in the middle of a read
        line = rnd_line();
        i_addr = 32'h1000_1000; i_read = 1'b1;
        serve_read("t4", 32'h1000_1000, line, 2, 1'b1);
        wait_resp("t4", gi, gd);
        chk("t4 line", i_rdata, line);
        chk("t4 err", err, 1);
        i_read = 1'b0;
        repeat (3) tick;
        chk("t4 sticky", err, 1);

        // 5: reset during beats, late beats land in IDLE
        reset_dut();
        tick;
        line = rnd_line(); n0 = i_resp_n + d_resp_n;
        d_addr = 32'h4000_0080; d_read = 1'b1;
        for (int c = 0; c < 20 && !bmem_read; c++) tick;
        chk("t5 cmd", bmem_read, 1);
        tick;
        for (int k = 0; k < 2; k++) begin
            bmem_rvalid = 1'b1; bmem_raddr = 32'h4000_0080; bmem_rdata = line[k*64 +: 64];
            tick;
        end
        bmem_rvalid = 1'b0; rst = 1'b0; d_read = 1'b0;
        tick;
        rst = 1'b1;
        chk("t5 bus idle", {bmem_read, bmem_write}, 0);
        chk("t5 d_rdata", d_rdata, 0);
        for (int k = 2; k < 4; k++) begin
            bmem_rvalid = 1'b1; bmem_raddr = 32'h4000_0080; bmem_rdata = line[k*64 +: 64];
            tick;
        end
        bmem_rvalid = 1'b0;
        tick;
        chk("t5 no resp", i_resp_n + d_resp_n - n0, 0);
        chk("t5 err", err, 0);
        line = rnd_line(); d_model = '0;
        i_addr = 32'h1000_2000; i_read = 1'b1;
        serve_read("t5b", 32'h1000_2000, line, 1, 1'b0);
        wait_resp("t5b", gi, gd);
        chk("t5b line", i_rdata, line);
        i_read = 1'b0;
        tick;
        chk("t5b err", err, 0);

        // 6: read+write together on unaligned address
        line = rnd_line(); wr_acc.delete(); wr_addr.delete();
        d_addr = 32'h3000_0013; d_wdata = line; d_read = 1'b1; d_write = 1'b1;
        serve_write("t6", 0, 0, 1'b1);
        wait_resp("t6", gi, gd);
        chk("t6 who", {gi, gd}, 2'b01);
        d_read = 1'b0; d_write = 1'b0;
        tick;
        chk("t6 nacc", wr_acc.size(), 4);
        for (int k = 0; k < wr_acc.size() && k < 4; k++)
            chk($sformatf("t6 beat%0d", k), wr_acc[k], line[k*64 +: 64]);
        chk("t6 addr", wr_addr[0], 32'h3000_0000);
        chk("t6 err", err, 1);

        // Random single-client traffic
        reset_dut();
        d_model = '0;
        for (int n = 0; n < 10; n++) begin
            kind = $urandom_range(0, 2);
            a = $urandom; line = rnd_line();
            if (kind == 0) begin
                i_addr = a; i_read = 1'b1;
                serve_read("rnd ird", {a[31:5], 5'b0}, line, $urandom_range(1, 4), 1'b0);
                wait_resp("rnd ird", gi, gd);
                chk("rnd ird who", {gi, gd}, 2'b10);
                chk("rnd ird line", i_rdata, line);
                i_read = 1'b0;
            end else if (kind == 1) begin
                d_addr = a; d_read = 1'b1;
                serve_read("rnd drd", {a[31:5], 5'b0}, line, $urandom_range(1, 4), 1'b0);
                wait_resp("rnd drd", gi, gd);
                chk("rnd drd who", {gi, gd}, 2'b01);
                chk("rnd drd line", d_rdata, line);
                d_model = line;
                d_read = 1'b0;
            end else begin
                wr_acc.delete(); wr_addr.delete();
                d_addr = a; d_wdata = line; d_write = 1'b1;
                serve_write("rnd dwr", 0, 0, 1'b1);
                wait_resp("rnd dwr", gi, gd);
                chk("rnd dwr who", {gi, gd}, 2'b01);
                chk("rnd dwr hold", d_rdata, d_model);
                d_write = 1'b0;
                chk("rnd dwr nacc", wr_acc.size(), 4);
                for (int k = 0; k < wr_acc.size() && k < 4; k++)
                    chk("rnd dwr beat", wr_acc[k], line[k*64 +: 64]);
                chk("rnd dwr addr", wr_addr[0], {a[31:5], 5'b0});
            end
            tick;
        end
        chk("rnd err", err, 0);
        chk("never rd+wr", overlap_n, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
